mem_align_seq: RTL
==================

Name: mem_align_seq

Overview:
- Load/store access sequencer placed directly upstream of the data memory. It sits between the core's datapath/control and the DM port.
- Aligned accesses pass straight through with zero added latency.
- Misaligned halfword/word accesses are split into aligned word reads and, for stores, read-modify-write word writes. The core is stalled via req_ready until the access completes.

Parameters:
- CNT_W, 16, width of the saturating misaligned-access counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  memory access request, held stable by core until req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  9  byte address; word index = addr[8:2] (128 words)
- req_wdata  in  32  store data (low bytes used for SB/SH)
- req_ld  in  3  load type: LB/LBU/LH/LHU/LW codes
- req_sv  in  2  store type: SB/SH/SW codes
- req_ready  out  1  access completes this cycle; core may advance on next edge
- resp_rdata  out  32  extended load result, valid when req_ready & ~req_we
- mem_addr  out  9  DM byte address
- mem_we  out  1  DM write enable
- mem_din  out  32  DM write data
- mem_ld  out  3  DM load type
- mem_sv  out  2  DM store type
- mem_dout  in  32  DM combinational read data
- misalign_cnt  out  CNT_W  count of misaligned accesses, saturating
- misalign_err  out  1  trap pulse; only when MISALIGN_TRAP_EN is defined, else tied 0

Behaviour:
- Misaligned condition:
  - halfword: addr[1:0]==3
  - word: addr[1:0]!=0
  - byte accesses are never misaligned
- off = addr[1:0]; lo = addr[8:2]; hi = lo+1 modulo 128, so word 127 wraps to word 0.
- FSM states: IDLE, RD_HI, WR_LO, WR_HI.
  - IDLE, aligned or no request: mem_* = req_* (mem_we = req_valid&req_we); resp_rdata = mem_dout; req_ready = req_valid.
  - IDLE, misaligned request:
    - Drive mem_addr = {lo,2'b00}, mem_ld = LW, mem_we = 0.
    - Latch w0 = mem_dout; req_ready = 0; go RD_HI.
  - RD_HI:
    - Drive mem_addr = {hi,2'b00}, LW.
    - Load: resp_rdata = extend(({mem_dout,w0} >> 8*off)[15:0 or 31:0]) per req_ld; req_ready = 1; go IDLE.
    - Store: latch w1 = mem_dout; go WR_LO.
  - WR_LO: mem_we = 1, mem_sv = SW, mem_addr = {lo,2'b00}, mem_din = merged[31:0]; go WR_HI.
  - WR_HI: mem_we = 1, mem_addr = {hi,2'b00}, mem_din = merged[63:32]; req_ready = 1; go IDLE.
  - merged = {w1,w0} with bytes off..off+n-1 replaced by req_wdata[8n-1:0], where n = 2 (SH) or 4 (SW).
- Latency:
  - aligned: 0 extra cycles
  - misaligned load: 2 cycles, ready in 2nd
  - misaligned store: 4 cycles, ready in 4th
- Sign extension: LH sign-extends from bit 15, LHU zero-extends; LW takes 32 bits unchanged.
- misalign_cnt increments by 1 on entry to RD_HI and saturates at all-ones.
- Reset, while rst is high, forces all of the following:
  - state = IDLE; w0, w1, misalign_cnt = 0
  - req_ready = 0, mem_we = 0, resp_rdata = 0, misalign_err = 0
- Reset mid-operation aborts the access and issues no further writes. A word already written in WR_LO stays written, so a store can be left half done.
- req_valid deasserting mid-sequence is a protocol violation; the sequence still completes.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned requests are not split.
  - In IDLE: misalign_err = 1 for one cycle, req_ready = 1, mem_we = 0, resp_rdata = 0, misalign_cnt increments.
  - No FSM states beyond IDLE are used.
- Undefined: split/RMW behaviour as above; misalign_err tied 0.

Decomposition:
- The LB/LBU/LH/LHU/LW and SB/SH/SW codes come from the shared ctrl_encode_def.v definitions.
- The FSM state encodings are added to that file as constants.
- One sub-module: mem_align_merge, purely combinational. It performs the load byte-select/extension and the store merge from {w1,w0}, off, size, wdata.

Test Plan:
- Preload word0=0x44332211, word1=0x88776655, word2=0x000000AA, word127=0x12345678.
- Aligned LW at 0x004 -> same cycle req_ready=1, rdata=0x88776655, misalign_cnt=0.
- LW at 0x003 -> req_ready 0 then 1; rdata=0x77665544; misalign_cnt=1.
- LH at 0x007 -> 0xFFFFAA88; LHU at 0x007 -> 0x0000AA88; LH at 0x002 (aligned) -> 0x00004433 in 0 extra cycles.
- SW 0xDEADBEEF at 0x002 -> ready on 4th cycle; word0=0xBEEF2211, word1=0x8877DEAD; exactly two mem_we pulses.
- LW at 0x1FE -> wraps to word0; rdata=0x22111234.
- rst pulse in WR_HI of an SW at 0x002 -> word0 updated, word1 unchanged, state IDLE, misalign_cnt=0. With MISALIGN_TRAP_EN: LW at 0x001 -> misalign_err=1 for one cycle, rdata=0, no DM write.

Source files
------------

// File: rtl/mem_align_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align_seq_pkg                                                    |
// | Load/store type codes, sequencer state encodings, misalign helper.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_align_seq_pkg;

    // Load type codes shared with the core control encoding
    localparam logic [2:0] c_ld_lw  = 3'd0;
    localparam logic [2:0] c_ld_lh  = 3'd1;
    localparam logic [2:0] c_ld_lhu = 3'd2;
    localparam logic [2:0] c_ld_lb  = 3'd3;
    localparam logic [2:0] c_ld_lbu = 3'd4;

    localparam logic [1:0] c_sv_sw  = 2'd0;
    localparam logic [1:0] c_sv_sh  = 2'd1;
    localparam logic [1:0] c_sv_sb  = 2'd2;

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_rd_hi = 2'd1;
    localparam logic [1:0] c_s_wr_lo = 2'd2;
    localparam logic [1:0] c_s_wr_hi = 2'd3;

    // Halfwords only straddle a word boundary at offset 3; bytes never do
    function automatic logic is_misaligned(input logic       we,
                                           input logic [2:0] ld,
                                           input logic [1:0] sv,
                                           input logic [1:0] off);
        logic r;
        r = 1'b0;
        if (we) begin
            if (sv == c_sv_sw)      r = (off != 2'd0);
            else if (sv == c_sv_sh) r = (off == 2'd3);
        end else begin
            if (ld == c_ld_lw)                         r = (off != 2'd0);
            else if (ld == c_ld_lh || ld == c_ld_lhu)  r = (off == 2'd3);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align_seq_if                                                     |
// | Core request/response and data-memory port bundle.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_align_seq_if;
    logic        req_valid;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ld;
    logic [1:0]  req_sv;
    logic        req_ready;
    logic [31:0] resp_rdata;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_din;
    logic [2:0]  mem_ld;
    logic [1:0]  mem_sv;
    logic [31:0] mem_dout;

    // master: core plus data memory; slave: the sequencer between them
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_ld, req_sv, mem_dout,
        input  req_ready, resp_rdata, mem_addr, mem_we, mem_din, mem_ld, mem_sv
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_ld, req_sv, mem_dout,
        output req_ready, resp_rdata, mem_addr, mem_we, mem_din, mem_ld, mem_sv
    );
endinterface
`default_nettype wire

// File: rtl/mem_align_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align_merge                                                      |
// | Combinational load byte-select/extend and store byte merge.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_align_merge
    import mem_align_seq_pkg::*;
(
    input  wire logic [31:0] i_lo_word,
    input  wire logic [31:0] i_hi_word,
    input  wire logic [1:0]  i_off,
    input  wire logic [2:0]  i_ld,
    input  wire logic        i_st_half,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_load_data,
    output logic      [63:0] o_merged
);

    logic [63:0] w_pair;
    logic [31:0] w_window;
    logic [2:0]  w_byte;

    assign w_pair   = {i_hi_word, i_lo_word};
    assign w_window = w_pair[{i_off, 3'b000} +: 32];

    always_comb begin
        case (i_ld)
            c_ld_lh:  o_load_data = {{16{w_window[15]}}, w_window[15:0]};
            c_ld_lhu: o_load_data = {16'h0000, w_window[15:0]};
            default:  o_load_data = w_window;
        endcase
    end

    // Replace bytes off..off+n-1 of the two-word pair with store data
    always_comb begin
        o_merged = w_pair;
        w_byte   = 3'd0;
        for (int k = 0; k < 4; k++) begin
            w_byte = {1'b0, i_off} + 3'(k);
            if (k < 2 || !i_st_half)
                o_merged[{w_byte, 3'b000} +: 8] = i_wdata[k*8 +: 8];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_align_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align_seq                                                        |
// | Splits misaligned loads/stores into aligned word reads and RMW       |
// | writes. Define MISALIGN_TRAP_EN to trap instead of splitting.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_align_seq
    import mem_align_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    mem_align_seq_if.slave        bus,
    output logic      [CNT_W-1:0] misalign_cnt,
    output logic                  misalign_err
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [31:0]      r_w0;
    logic [31:0]      r_w1;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_off;
    logic [6:0]       w_lo;
    logic [6:0]       w_hi;
    logic             w_mis;
    logic             w_err;
    logic [31:0]      w_hi_word;
    logic [31:0]      w_load_data;
    logic [63:0]      w_merged;

    assign w_off = bus.req_addr[1:0];
    assign w_lo  = bus.req_addr[8:2];
    assign w_hi  = w_lo + 7'd1;
    assign w_mis = bus.req_valid
                 & is_misaligned(bus.req_we, bus.req_ld, bus.req_sv, w_off);

    // High word is still on the memory bus during RD_HI, latched afterwards
    assign w_hi_word = (r_state == c_s_rd_hi) ? bus.mem_dout : r_w1;

    mem_align_merge u_merge (
        .i_lo_word   (r_w0),
        .i_hi_word   (w_hi_word),
        .i_off       (w_off),
        .i_ld        (bus.req_ld),
        .i_st_half   (bus.req_sv == c_sv_sh),
        .i_wdata     (bus.req_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_s_idle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_idle: begin
`ifdef MISALIGN_TRAP_EN
                w_next = c_s_idle;
`else
                if (w_mis) w_next = c_s_rd_hi;
`endif
            end
            c_s_rd_hi: w_next = bus.req_we ? c_s_wr_lo : c_s_idle;
            c_s_wr_lo: w_next = c_s_wr_hi;
            c_s_wr_hi: w_next = c_s_idle;
            default:   w_next = c_s_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w0  <= '0;
            r_w1  <= '0;
            r_cnt <= '0;
        end else begin
            if (r_state == c_s_idle && w_mis) begin
`ifndef MISALIGN_TRAP_EN
                r_w0 <= bus.mem_dout;
`endif
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == c_s_rd_hi && bus.req_we)
                r_w1 <= bus.mem_dout;
        end
    end

    always_comb begin
        bus.mem_addr   = bus.req_addr;
        bus.mem_we     = bus.req_valid & bus.req_we;
        bus.mem_din    = bus.req_wdata;
        bus.mem_ld     = bus.req_ld;
        bus.mem_sv     = bus.req_sv;
        bus.resp_rdata = bus.mem_dout;
        bus.req_ready  = bus.req_valid;
        w_err          = 1'b0;
        case (r_state)
            c_s_idle: begin
                if (w_mis) begin
`ifdef MISALIGN_TRAP_EN
                    w_err          = 1'b1;
                    bus.req_ready  = 1'b1;
                    bus.mem_we     = 1'b0;
                    bus.resp_rdata = '0;
`else
                    bus.mem_addr   = {w_lo, 2'b00};
                    bus.mem_ld     = c_ld_lw;
                    bus.mem_we     = 1'b0;
                    bus.req_ready  = 1'b0;
                    bus.resp_rdata = '0;
`endif
                end
            end
            c_s_rd_hi: begin
                bus.mem_addr   = {w_hi, 2'b00};
                bus.mem_ld     = c_ld_lw;
                bus.mem_we     = 1'b0;
                bus.mem_sv     = c_sv_sw;
                bus.req_ready  = ~bus.req_we;
                bus.resp_rdata = bus.req_we ? 32'h0 : w_load_data;
            end
            c_s_wr_lo: begin
                bus.mem_addr   = {w_lo, 2'b00};
                bus.mem_ld     = c_ld_lw;
                bus.mem_we     = 1'b1;
                bus.mem_sv     = c_sv_sw;
                bus.mem_din    = w_merged[31:0];
                bus.req_ready  = 1'b0;
                bus.resp_rdata = '0;
            end
            default: begin
                bus.mem_addr   = {w_hi, 2'b00};
                bus.mem_ld     = c_ld_lw;
                bus.mem_we     = 1'b1;
                bus.mem_sv     = c_sv_sw;
                bus.mem_din    = w_merged[63:32];
                bus.req_ready  = 1'b1;
                bus.resp_rdata = '0;
            end
        endcase
        // Reset kills any in-flight write immediately, not at the next edge
        if (rst) begin
            bus.req_ready  = 1'b0;
            bus.mem_we     = 1'b0;
            bus.resp_rdata = '0;
            w_err          = 1'b0;
        end
    end

    assign misalign_cnt = r_cnt;
    assign misalign_err = w_err;

endmodule
`default_nettype wire
